// File: rtl/instruction_fetch_queue.sv
// -----------------------------------------------------------------------------
// instruction_fetch_queue
//
// Fetch front end for the IF/ID barrier. Owns the fetch PC, issues one request
// at a time to a variable-latency instruction memory and buffers returned words
// in a small FIFO whose head is presented to IF/ID.
//
// Ports
//   clk            rising-edge clock
//   resetN         asynchronous reset, active low
//   memReq         fetch request valid (IDLE, room in the queue, no redirect)
//   memAddr        fetch address, held while memReq && !memReady
//   memReady       memory accepts the request this cycle
//   memRespValid   response word valid (in order, at most one outstanding)
//   memRespData    response instruction word
//   isStalled      head entry must not be consumed this cycle
//   redirectValid  one-cycle branch/jump redirect pulse
//   redirectPc     redirect target
//   ifValid        FIFO head valid
//   ifInstruction  head instruction, NOP when empty
//   ifPc           head PC, 0 when empty
//   queueCount     number of occupied FIFO entries
// -----------------------------------------------------------------------------
module instruction_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                    clk,
  input  logic                    resetN,
  output logic                    memReq,
  output logic [31:0]             memAddr,
  input  logic                    memReady,
  input  logic                    memRespValid,
  input  logic [31:0]             memRespData,
  input  logic                    isStalled,
  input  logic                    redirectValid,
  input  logic [31:0]             redirectPc,
  output logic                    ifValid,
  output logic [31:0]             ifInstruction,
  output logic [31:0]             ifPc,
  output logic [$clog2(DEPTH):0]  queueCount
);

  localparam int unsigned        PTR_W      = $clog2(DEPTH);
  localparam logic [31:0]        NOP        = 32'h00000013;
  localparam logic [PTR_W:0]     FULL_COUNT = DEPTH[PTR_W:0];

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        fetch_pc_q, fetch_pc_d;
  logic [31:0]        req_pc_q, req_pc_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]     count_q, count_d;

  logic [31:0]        pc_mem    [DEPTH];
  logic [31:0]        instr_mem [DEPTH];

  logic               not_full;
  logic               fire;
  logic               push;
  logic               pop;

  // Request is gated by resetN so memReq is low for the whole reset period,
  // not only after the first edge.
  assign not_full = (count_q < FULL_COUNT);
  assign memReq   = resetN && (state_q == IDLE) && not_full && !redirectValid;
  assign memAddr  = fetch_pc_q;
  assign fire     = memReq && memReady;

  assign ifValid       = (count_q != '0);
  assign ifInstruction = ifValid ? instr_mem[rd_ptr_q] : NOP;
  assign ifPc          = ifValid ? pc_mem[rd_ptr_q] : 32'h0;
  assign queueCount    = count_q;

  // A redirect suppresses both queue operations in its cycle.
  assign push = (state_q == WAIT) && memRespValid && !redirectValid;
  assign pop  = ifValid && !isStalled && !redirectValid;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;

    if (redirectValid) begin
      fetch_pc_d = redirectPc;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      unique case (state_q)
        IDLE:    state_d = IDLE;
        // The outstanding word belongs to the old path; if it is not here
        // yet it still has to be absorbed before a new request can issue.
        WAIT:    state_d = memRespValid ? IDLE : DISCARD;
        // A word arriving in this very cycle retires the old request, so
        // staying in DISCARD would wait for a response that never comes.
        DISCARD: state_d = memRespValid ? IDLE : DISCARD;
        default: state_d = IDLE;
      endcase
    end else begin
      unique case (state_q)
        IDLE: begin
          if (fire) begin
            req_pc_d   = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + 32'd4;
            state_d    = WAIT;
          end
        end
        WAIT:    if (memRespValid) state_d = IDLE;
        DISCARD: if (memRespValid) state_d = IDLE;
        default: state_d = IDLE;
      endcase

      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + (PTR_W+1)'(1);
        2'b01:   count_d = count_q - (PTR_W+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // Storage needs no reset: an entry is only observable while count_q covers it.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]    <= req_pc_q;
      instr_mem[wr_ptr_q] <= memRespData;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch_queue
//
// Scoreboard bench. Stimulus seeds the expected PC stream whenever it starts or
// redirects fetching; a monitor pops and compares every head entry that IF/ID
// consumes. A behavioural memory with programmable latency answers requests.
// A second instance with RESET_PC = 32'hFFFFFFFC covers address wrap.
// -----------------------------------------------------------------------------
module tb_instruction_fetch_queue;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        resetN;
  logic        memReq;
  logic [31:0] memAddr;
  logic        memReady;
  logic        memRespValid;
  logic [31:0] memRespData;
  logic        isStalled;
  logic        redirectValid;
  logic [31:0] redirectPc;
  logic        ifValid;
  logic [31:0] ifInstruction;
  logic [31:0] ifPc;
  logic [2:0]  queueCount;

  logic        memReq2;
  logic [31:0] memAddr2;
  logic        ready2;
  logic        resp_valid2;
  logic [31:0] resp_data2;
  logic        stall2;
  logic        redirect2;
  logic [31:0] redirect_pc2;
  logic        ifValid2;
  logic [31:0] ifInstruction2;
  logic [31:0] ifPc2;
  logic [2:0]  queueCount2;

  always #5 clk = ~clk;

  instruction_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) u_dut (
    .clk(clk), .resetN(resetN),
    .memReq(memReq), .memAddr(memAddr), .memReady(memReady),
    .memRespValid(memRespValid), .memRespData(memRespData),
    .isStalled(isStalled), .redirectValid(redirectValid), .redirectPc(redirectPc),
    .ifValid(ifValid), .ifInstruction(ifInstruction), .ifPc(ifPc),
    .queueCount(queueCount)
  );

  instruction_fetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFFFFFC)) u_dut_wrap (
    .clk(clk), .resetN(resetN),
    .memReq(memReq2), .memAddr(memAddr2), .memReady(ready2),
    .memRespValid(resp_valid2), .memRespData(resp_data2),
    .isStalled(stall2), .redirectValid(redirect2), .redirectPc(redirect_pc2),
    .ifValid(ifValid2), .ifInstruction(ifInstruction2), .ifPc(ifPc2),
    .queueCount(queueCount2)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int pop_cnt  = 0;
  int mem_lat  = 1;

  logic [31:0] exp_q [$];
  logic [31:0] addr_base  = 32'h0;
  int          addr_epoch = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0003;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, got, exp);
  endtask

  // Expected fetch stream starting at pc, consumed by the monitor.
  task automatic seed(input logic [31:0] pc);
    exp_q.delete();
    for (int i = 0; i < 64; i++) exp_q.push_back(pc + 32'(4 * i));
    addr_base  = pc;
    addr_epoch = addr_epoch + 1;
  endtask

  // Behavioural memory: request sampled mid-cycle, answered mem_lat cycles later.
  logic        pend = 1'b0;
  int          pend_cnt = 0;
  logic [31:0] pend_addr = 32'h0;
  always begin
    @(negedge clk);
    if (resetN && memReq && memReady) begin
      pend      = 1'b1;
      pend_cnt  = mem_lat;
      pend_addr = memAddr;
    end
    @(posedge clk);
    #1;
    memRespValid = 1'b0;
    if (!resetN) begin
      pend = 1'b0;
    end else if (pend) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        memRespValid = 1'b1;
        memRespData  = mem_word(pend_addr);
        pend         = 1'b0;
      end
    end
  end

  // Scoreboard monitor: every consumed head entry must be the next expected PC.
  always @(negedge clk) begin
    if (resetN && ifValid && !isStalled && !redirectValid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL sb_empty: consumed pc %h, expected no entry", ifPc);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        chk("sb_pc", ifPc, e);
        chk("sb_instr", ifInstruction, mem_word(e));
      end
      pop_cnt++;
      $display("pop pc=%h instr=%h", ifPc, ifInstruction);
    end
  end

  // Accepted addresses must form a +4 sequence from the latest seed point.
  logic [31:0] exp_addr = 32'h0;
  int          seen_epoch = 0;
  always @(negedge clk) begin
    if (addr_epoch != seen_epoch) begin
      seen_epoch = addr_epoch;
      exp_addr   = addr_base;
    end
    if (resetN && memReq && memReady) begin
      chk("mem_addr_seq", memAddr, exp_addr);
      exp_addr = exp_addr + 32'd4;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: no finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int          base;
    logic        found;
    logic [31:0] held;

    resetN = 1'b0; memReady = 1'b1; isStalled = 1'b0;
    redirectValid = 1'b0; redirectPc = 32'h0;
    memRespValid = 1'b0; memRespData = 32'h0;
    ready2 = 1'b0; resp_valid2 = 1'b0; resp_data2 = 32'h0;
    stall2 = 1'b0; redirect2 = 1'b0; redirect_pc2 = 32'h0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_memReq", {31'b0, memReq}, 32'd0);
    chk("rst_ifValid", {31'b0, ifValid}, 32'd0);
    chk("rst_ifInstruction", ifInstruction, NOP);
    chk("rst_ifPc", ifPc, 32'h0);
    chk("rst_queueCount", {29'b0, queueCount}, 32'd0);
    chk("rst_memReq_wrap", {31'b0, memReq2}, 32'd0);

    // Sequential fetch with a 1-cycle memory: one instruction per 2 cycles
    @(posedge clk); #1;
    seed(32'h0);
    resetN = 1'b1;
    @(negedge clk);
    chk("first_memReq", {31'b0, memReq}, 32'd1);
    chk("first_memAddr", memAddr, 32'h0);
    repeat (12) @(negedge clk);
    #1;
    chk("stream_pop_count", pop_cnt, 6);

    // Stall: queue saturates, fetching stops, then 4 entries drain back-to-back
    @(posedge clk); #1;
    isStalled = 1'b1;
    repeat (20) @(negedge clk);
    chk("stall_queueCount", {29'b0, queueCount}, 32'd4);
    chk("stall_memReq", {31'b0, memReq}, 32'd0);
    chk("stall_ifValid", {31'b0, ifValid}, 32'd1);
    @(posedge clk); #1;
    isStalled = 1'b0;
    base = pop_cnt;
    repeat (4) begin
      @(negedge clk);
      chk("drain_ifValid", {31'b0, ifValid}, 32'd1);
    end
    #1;
    chk("drain_pop_count", pop_cnt - base, 4);

    // Back-pressure: request and address held until accepted
    @(posedge clk); #1;
    memReady = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (memReq) found = 1'b1;
    end
    chk("bp_req_seen", {31'b0, found}, 32'd1);
    held = memAddr;
    repeat (3) begin
      @(negedge clk);
      chk("bp_memReq_hold", {31'b0, memReq}, 32'd1);
      chk("bp_memAddr_hold", memAddr, held);
    end
    @(posedge clk); #1;
    memReady = 1'b1;
    @(negedge clk);
    chk("bp_addr_at_accept", memAddr, held);
    @(negedge clk);
    chk("bp_wait_memReq", {31'b0, memReq}, 32'd0);

    // Redirect while a slow request is outstanding: stale word must vanish
    @(posedge clk); #1;
    mem_lat = 3;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (memReq && memReady) found = 1'b1;
    end
    chk("redir_wait_seen", {31'b0, found}, 32'd1);
    @(posedge clk); #1;
    redirectValid = 1'b1;
    redirectPc = 32'h100;
    seed(32'h100);
    @(posedge clk); #1;
    redirectValid = 1'b0;
    @(negedge clk);
    chk("redir_flush_ifValid", {31'b0, ifValid}, 32'd0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (ifValid) found = 1'b1;
    end
    chk("redir_head_seen", {31'b0, found}, 32'd1);
    chk("redir_head_pc", ifPc, 32'h100);
    @(posedge clk); #1;
    mem_lat = 1;

    // Redirect coinciding with a response and a pop
    @(posedge clk); #1;
    isStalled = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (queueCount >= 3'd2 && memReq && memReady) found = 1'b1;
    end
    chk("coll_setup_seen", {31'b0, found}, 32'd1);
    @(posedge clk); #1;
    isStalled = 1'b0;
    redirectValid = 1'b1;
    redirectPc = 32'h200;
    seed(32'h200);
    @(negedge clk);
    chk("coll_resp_present", {31'b0, memRespValid}, 32'd1);
    chk("coll_head_present", {31'b0, ifValid}, 32'd1);
    @(posedge clk); #1;
    redirectValid = 1'b0;
    @(negedge clk);
    chk("coll_ifValid", {31'b0, ifValid}, 32'd0);
    chk("coll_queueCount", {29'b0, queueCount}, 32'd0);
    chk("coll_memReq", {31'b0, memReq}, 32'd1);
    chk("coll_memAddr", memAddr, 32'h200);
    repeat (6) @(negedge clk);

    // Address wrap from RESET_PC = FFFFFFFC
    @(posedge clk); #1;
    ready2 = 1'b1;
    @(negedge clk);
    chk("wrap_memReq_first", {31'b0, memReq2}, 32'd1);
    chk("wrap_memAddr_first", memAddr2, 32'hFFFFFFFC);
    @(posedge clk); #1;
    ready2 = 1'b0;
    resp_valid2 = 1'b1;
    resp_data2 = 32'h12345678;
    @(negedge clk);
    chk("wrap_wait_memReq", {31'b0, memReq2}, 32'd0);
    @(posedge clk); #1;
    resp_valid2 = 1'b0;
    @(negedge clk);
    chk("wrap_memReq_second", {31'b0, memReq2}, 32'd1);
    chk("wrap_memAddr_second", memAddr2, 32'h0);
    chk("wrap_ifValid", {31'b0, ifValid2}, 32'd1);
    chk("wrap_ifPc", ifPc2, 32'hFFFFFFFC);
    chk("wrap_ifInstruction", ifInstruction2, 32'h12345678);

    // Asynchronous reset in the middle of a WAIT with a non-empty queue
    @(posedge clk); #1;
    isStalled = 1'b1;
    mem_lat = 3;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (queueCount >= 3'd1 && memReq && memReady) found = 1'b1;
    end
    chk("arst_setup_seen", {31'b0, found}, 32'd1);
    @(posedge clk); #3;
    resetN = 1'b0;
    #1;
    chk("arst_memReq", {31'b0, memReq}, 32'd0);
    chk("arst_ifValid", {31'b0, ifValid}, 32'd0);
    chk("arst_ifInstruction", ifInstruction, NOP);
    chk("arst_ifPc", ifPc, 32'h0);
    chk("arst_queueCount", {29'b0, queueCount}, 32'd0);
    chk("arst_wrap_ifValid", {31'b0, ifValid2}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    seed(32'h0);
    isStalled = 1'b0;
    mem_lat = 1;
    resetN = 1'b1;
    base = pop_cnt;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      #1;
      if (pop_cnt - base >= 3) found = 1'b1;
    end
    chk("arst_restart_pops", {31'b0, found}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
